// File: rtl/apb4_master_bridge.sv
// Single-outstanding APB4 initiator: valid/ready request in, SETUP/ACCESS on APB,
// valid/ready response out, with an optional PREADY wait-state timeout.
module apb4_master_bridge #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                    pclk,
    input  logic                    preset,

    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic [ADDR_WIDTH-1:0]   req_addr_i,
    input  logic                    req_write_i,
    input  logic [DATA_WIDTH-1:0]   req_wdata_i,
    input  logic [DATA_WIDTH/8-1:0] req_strb_i,
    input  logic [2:0]              req_prot_i,

    output logic                    rsp_valid_o,
    input  logic                    rsp_ready_i,
    output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
    output logic                    rsp_slverr_o,
    output logic                    rsp_timeout_o,

    output logic [ADDR_WIDTH-1:0]   paddr_o,
    output logic [2:0]              pprot_o,
    output logic                    psel_o,
    output logic                    penable_o,
    output logic                    pwrite_o,
    output logic [DATA_WIDTH-1:0]   pwdata_o,
    output logic [DATA_WIDTH/8-1:0] pstrb_o,
    input  logic                    pready_i,
    input  logic [DATA_WIDTH-1:0]   prdata_i,
    input  logic                    pslverr_i
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES > 0);
    localparam int CNT_WIDTH  = TIMEOUT_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam int LAST_INT   = TIMEOUT_EN ? TIMEOUT_CYCLES - 1 : 0;
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(LAST_INT);

    if (DATA_WIDTH != 8 && DATA_WIDTH != 16 && DATA_WIDTH != 32) begin : g_bad_data_width
        $error("apb4_master_bridge: DATA_WIDTH must be 8, 16 or 32");
    end

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP
    } state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   paddr_q, paddr_d;
    logic [2:0]              pprot_q, pprot_d;
    logic                    pwrite_q, pwrite_d;
    logic [DATA_WIDTH-1:0]   pwdata_q, pwdata_d;
    logic [STRB_WIDTH-1:0]   pstrb_q, pstrb_d;
    logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                    rsp_slverr_q, rsp_slverr_d;
    logic                    rsp_timeout_q, rsp_timeout_d;

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state_q       <= IDLE;
            paddr_q       <= '0;
            pprot_q       <= '0;
            pwrite_q      <= 1'b0;
            pwdata_q      <= '0;
            pstrb_q       <= '0;
            cnt_q         <= '0;
            rsp_rdata_q   <= '0;
            rsp_slverr_q  <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            paddr_q       <= paddr_d;
            pprot_q       <= pprot_d;
            pwrite_q      <= pwrite_d;
            pwdata_q      <= pwdata_d;
            pstrb_q       <= pstrb_d;
            cnt_q         <= cnt_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_slverr_q  <= rsp_slverr_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        paddr_d       = paddr_q;
        pprot_d       = pprot_q;
        pwrite_d      = pwrite_q;
        pwdata_d      = pwdata_q;
        pstrb_d       = pstrb_q;
        cnt_d         = cnt_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_slverr_d  = rsp_slverr_q;
        rsp_timeout_d = rsp_timeout_q;

        case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    paddr_d  = req_addr_i;
                    pprot_d  = req_prot_i;
                    pwrite_d = req_write_i;
                    pwdata_d = req_wdata_i;
                    pstrb_d  = req_write_i ? req_strb_i : '0;
                    cnt_d    = '0;
                    state_d  = SETUP;
                end
            end
            SETUP: begin
                state_d = ACCESS;
            end
            ACCESS: begin
                // Completion wins over timeout when pready arrives on the last allowed cycle.
                if (pready_i) begin
                    rsp_slverr_d  = pslverr_i;
                    rsp_timeout_d = 1'b0;
                    rsp_rdata_d   = pwrite_q ? '0 : prdata_i;
                    state_d       = RESP;
                end else if (TIMEOUT_EN && (cnt_q == CNT_LAST)) begin
                    rsp_slverr_d  = 1'b1;
                    rsp_timeout_d = 1'b1;
                    rsp_rdata_d   = '0;
                    state_d       = RESP;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                end
            end
            RESP: begin
                if (rsp_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign req_ready_o   = (state_q == IDLE);
    assign psel_o        = (state_q == SETUP) || (state_q == ACCESS);
    assign penable_o     = (state_q == ACCESS);
    assign rsp_valid_o   = (state_q == RESP);

    assign paddr_o       = paddr_q;
    assign pprot_o       = pprot_q;
    assign pwrite_o      = pwrite_q;
    assign pwdata_o      = pwdata_q;
    assign pstrb_o       = pstrb_q;

    assign rsp_rdata_o   = rsp_rdata_q;
    assign rsp_slverr_o  = rsp_slverr_q;
    assign rsp_timeout_o = rsp_timeout_q;

endmodule

// File: tb/tb_apb4_master_bridge.sv
// Bench for apb4_master_bridge: directed vector table, randomized transfers checked
// against a transaction-level model, and an asynchronous reset during ACCESS.
module tb_apb4_master_bridge;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int TO = 4;

    logic          pclk = 1'b0;
    logic          preset;
    logic          req_valid;
    logic          req_ready_o;
    logic [AW-1:0] req_addr;
    logic          req_write;
    logic [DW-1:0] req_wdata;
    logic [SW-1:0] req_strb;
    logic [2:0]    req_prot;
    logic          rsp_valid_o;
    logic          rsp_ready;
    logic [DW-1:0] rsp_rdata_o;
    logic          rsp_slverr_o;
    logic          rsp_timeout_o;
    logic [AW-1:0] paddr_o;
    logic [2:0]    pprot_o;
    logic          psel_o;
    logic          penable_o;
    logic          pwrite_o;
    logic [DW-1:0] pwdata_o;
    logic [SW-1:0] pstrb_o;
    logic          pready;
    logic [DW-1:0] prdata;
    logic          pslverr;

    int unsigned vectors    = 0;
    int unsigned miscompares = 0;

    always #5 pclk = ~pclk;

    apb4_master_bridge #(
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .pclk          (pclk),
        .preset        (preset),
        .req_valid_i   (req_valid),
        .req_ready_o   (req_ready_o),
        .req_addr_i    (req_addr),
        .req_write_i   (req_write),
        .req_wdata_i   (req_wdata),
        .req_strb_i    (req_strb),
        .req_prot_i    (req_prot),
        .rsp_valid_o   (rsp_valid_o),
        .rsp_ready_i   (rsp_ready),
        .rsp_rdata_o   (rsp_rdata_o),
        .rsp_slverr_o  (rsp_slverr_o),
        .rsp_timeout_o (rsp_timeout_o),
        .paddr_o       (paddr_o),
        .pprot_o       (pprot_o),
        .psel_o        (psel_o),
        .penable_o     (penable_o),
        .pwrite_o      (pwrite_o),
        .pwdata_o      (pwdata_o),
        .pstrb_o       (pstrb_o),
        .pready_i      (pready),
        .prdata_i      (prdata),
        .pslverr_i     (pslverr)
    );

    typedef struct {
        logic [AW-1:0] addr;
        logic          write;
        logic [DW-1:0] wdata;
        logic [SW-1:0] strb;
        logic [2:0]    prot;
        int unsigned   waits;   // ACCESS cycles the slave holds pready low
        logic          err;
        logic [DW-1:0] rdata;
        int unsigned   stall;   // cycles rsp_ready stays low once rsp_valid is up
        logic [DW-1:0] exp_rdata;
        logic          exp_slverr;
        logic          exp_timeout;
        int unsigned   exp_lat; // cycles from accept edge to rsp_valid
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Transaction-level expectation: the slave answers within TO ACCESS cycles or the transfer aborts.
    function automatic vec_t model(input vec_t v);
        vec_t r;
        bit   to;
        int unsigned access_cycles;
        r  = v;
        to = (v.waits >= TO);
        access_cycles = to ? TO : v.waits + 1;
        r.exp_timeout = to;
        r.exp_slverr  = to | v.err;
        r.exp_rdata   = (to || v.write) ? '0 : v.rdata;
        r.exp_lat     = 1 + access_cycles;
        return r;
    endfunction

    task automatic do_reset();
        preset    = 1'b1;
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        pready    = 1'b0;
        pslverr   = 1'b0;
        @(negedge pclk);
        @(negedge pclk);
        preset = 1'b0;
        @(negedge pclk);
    endtask

    // Entered and left on a negedge, with the bridge idle.
    task automatic run_xfer(input vec_t v, input string tag);
        int unsigned n, acc, psel_n, pen_n, apb_bad, ready_bad, stable_bad;
        bit          seen;
        logic [SW-1:0] exp_strb;
        exp_strb = v.write ? v.strb : '0;

        req_valid = 1'b1;
        req_addr  = v.addr;
        req_write = v.write;
        req_wdata = v.wdata;
        req_strb  = v.strb;
        req_prot  = v.prot;
        check({tag, ".req_ready_idle"}, req_ready_o, 1);
        @(posedge pclk);
        @(negedge pclk);
        req_valid = 1'b0;
        req_addr  = $urandom;
        req_wdata = $urandom;
        req_strb  = SW'($urandom);
        req_prot  = 3'($urandom);
        req_write = 1'($urandom);

        n = 0; acc = 0; psel_n = 0; pen_n = 0; apb_bad = 0; ready_bad = 0; stable_bad = 0;
        seen = 1'b0;
        while (!seen && n < 40) begin
            if (rsp_valid_o) begin
                seen = 1'b1;
            end else begin
                if (req_ready_o) ready_bad++;
                if (psel_o) begin
                    psel_n++;
                    if (paddr_o !== v.addr || pwrite_o !== v.write || pwdata_o !== v.wdata ||
                        pstrb_o !== exp_strb || pprot_o !== v.prot) apb_bad++;
                end
                if (penable_o) begin
                    pen_n++;
                    if (!psel_o) apb_bad++;
                    if (acc >= v.waits) begin
                        pready  = 1'b1;
                        pslverr = v.err;
                        prdata  = v.rdata;
                    end else begin
                        pready  = 1'b0;
                        pslverr = 1'($urandom);
                        prdata  = $urandom;
                    end
                    acc++;
                end else begin
                    pready  = 1'b0;
                    pslverr = 1'b0;
                end
                @(negedge pclk);
                n++;
            end
        end
        pready  = 1'b0;
        pslverr = 1'b0;

        check({tag, ".rsp_seen"}, seen, 1);
        if (!seen) begin
            do_reset();
            return;
        end
        check({tag, ".latency"}, n, v.exp_lat);
        check({tag, ".psel_cycles"}, psel_n, v.exp_lat);
        check({tag, ".penable_cycles"}, pen_n, v.exp_lat - 1);
        check({tag, ".apb_fields"}, apb_bad, 0);
        check({tag, ".req_ready_busy"}, ready_bad, 0);
        check({tag, ".psel_in_resp"}, {psel_o, penable_o}, 0);

        for (int unsigned s = 0; s < v.stall; s++) begin
            rsp_ready = 1'b0;
            if (rsp_valid_o !== 1'b1 || req_ready_o !== 1'b0 || rsp_rdata_o !== v.exp_rdata ||
                rsp_slverr_o !== v.exp_slverr || rsp_timeout_o !== v.exp_timeout) stable_bad++;
            @(negedge pclk);
        end
        check({tag, ".rsp_stable"}, stable_bad, 0);
        check({tag, ".rsp_valid"}, rsp_valid_o, 1);
        check({tag, ".rsp_rdata"}, rsp_rdata_o, v.exp_rdata);
        check({tag, ".rsp_slverr"}, rsp_slverr_o, v.exp_slverr);
        check({tag, ".rsp_timeout"}, rsp_timeout_o, v.exp_timeout);
        rsp_ready = 1'b1;
        @(negedge pclk);
        rsp_ready = 1'b0;
        check({tag, ".rsp_cleared"}, rsp_valid_o, 0);
        check({tag, ".req_ready_back"}, req_ready_o, 1);
    endtask

    vec_t table_v[6];
    vec_t rv;

    initial begin
        // addr, write, wdata, strb, prot, waits, err, rdata, stall | exp rdata, slverr, timeout, lat
        table_v[0] = '{32'h08, 1'b1, 32'hA5A5_0001, 4'hF, 3'd0, 0,   1'b0, 32'hDEAD_BEEF, 0, 32'h0,         1'b0, 1'b0, 2};
        table_v[1] = '{32'h04, 1'b0, 32'h0,         4'hF, 3'd2, 3,   1'b0, 32'h1234_5678, 0, 32'h1234_5678, 1'b0, 1'b0, 5};
        table_v[2] = '{32'h0C, 1'b1, 32'h0F0F_F0F0, 4'h3, 3'd1, 0,   1'b1, 32'h7777_7777, 5, 32'h0,         1'b1, 1'b0, 2};
        table_v[3] = '{32'h10, 1'b0, 32'h0,         4'hF, 3'd0, 100, 1'b0, 32'hFFFF_FFFF, 0, 32'h0,         1'b1, 1'b1, 5};
        table_v[4] = '{32'h14, 1'b0, 32'h0,         4'hC, 3'd7, 3,   1'b0, 32'hCAFE_F00D, 1, 32'hCAFE_F00D, 1'b0, 1'b0, 5};
        table_v[5] = '{32'h18, 1'b0, 32'h0,         4'h5, 3'd4, 1,   1'b1, 32'h55AA_55AA, 0, 32'h55AA_55AA, 1'b1, 1'b0, 3};

        preset    = 1'b1;
        req_valid = 1'b0;
        req_addr  = '0;
        req_write = 1'b0;
        req_wdata = '0;
        req_strb  = '0;
        req_prot  = '0;
        rsp_ready = 1'b0;
        pready    = 1'b0;
        prdata    = '0;
        pslverr   = 1'b0;
        #1;
        check("reset.req_ready", req_ready_o, 1);
        check("reset.psel_penable", {psel_o, penable_o}, 0);
        check("reset.rsp", {rsp_valid_o, rsp_slverr_o, rsp_timeout_o}, 0);
        check("reset.rsp_rdata", rsp_rdata_o, 0);
        check("reset.apb_regs", {paddr_o, pwdata_o, pstrb_o, pprot_o, pwrite_o}, 0);
        @(negedge pclk);
        @(negedge pclk);
        preset = 1'b0;
        @(negedge pclk);

        for (int i = 0; i < 6; i++) begin
            run_xfer(table_v[i], $sformatf("tbl%0d", i));
        end

        // Reset asserted between clock edges while the slave is inserting wait states.
        req_valid = 1'b1;
        req_addr  = 32'h20;
        req_write = 1'b0;
        req_strb  = 4'hF;
        req_prot  = 3'd3;
        @(posedge pclk);
        @(negedge pclk);
        req_valid = 1'b0;
        pready    = 1'b0;
        @(negedge pclk);
        check("rst_mid.in_access", {psel_o, penable_o}, 2'b11);
        #2 preset = 1'b1;
        #1;
        check("rst_mid.psel_penable", {psel_o, penable_o}, 0);
        check("rst_mid.rsp_valid", rsp_valid_o, 0);
        check("rst_mid.req_ready", req_ready_o, 1);
        check("rst_mid.paddr", paddr_o, 0);
        @(negedge pclk);
        preset = 1'b0;
        @(negedge pclk);
        rv = model('{32'h24, 1'b0, 32'h0, 4'hF, 3'd0, 2, 1'b0, 32'h0BAD_CAFE, 0, '0, 1'b0, 1'b0, 0});
        run_xfer(rv, "rst_mid.after");

        for (int i = 0; i < 40; i++) begin
            rv.addr  = $urandom & 32'hFFFF_FFFC;
            rv.write = 1'($urandom);
            rv.wdata = $urandom;
            rv.strb  = SW'($urandom);
            rv.prot  = 3'($urandom);
            rv.waits = $urandom_range(0, 6);
            rv.err   = ($urandom_range(0, 3) == 0);
            rv.rdata = $urandom;
            rv.stall = $urandom_range(0, 3);
            rv = model(rv);
            run_xfer(rv, $sformatf("rnd%0d", i));
            for (int unsigned g = $urandom_range(0, 2); g > 0; g--) @(negedge pclk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/apb4_master_bridge.md
Name: apb4_master_bridge

Overview:
- Single-outstanding APB4 initiator. It converts a valid/ready request channel into APB4 SETUP/ACCESS transfers and returns results on a valid/ready response channel.
- It is the requester side that drives the team's APB4 peripherals (GPIO, timers, etc.) from a core or debug port.
- Includes a configurable PREADY wait-state timeout, so a hung slave cannot stall the system.

Parameters:
ADDR_WIDTH, 32, APB address width
DATA_WIDTH, 32, APB data width; must be 8, 16 or 32
TIMEOUT_CYCLES, 256, max ACCESS-phase cycles with pready low before abort; 0 disables the timeout

Ports:
pclk  in  1  clock
preset  in  1  asynchronous reset, active-high
req_valid_i  in  1  request valid
req_ready_o  out  1  request accepted when high with req_valid_i
req_addr_i  in  ADDR_WIDTH  transfer address
req_write_i  in  1  1=write, 0=read
req_wdata_i  in  DATA_WIDTH  write data
req_strb_i  in  DATA_WIDTH/8  write byte strobes
req_prot_i  in  3  protection attributes
rsp_valid_o  out  1  response valid
rsp_ready_i  in  1  response consumed
rsp_rdata_o  out  DATA_WIDTH  read data; 0 for writes and timeouts
rsp_slverr_o  out  1  pslverr captured, or timeout
rsp_timeout_o  out  1  transfer aborted by timeout
paddr_o  out  ADDR_WIDTH  APB address
pprot_o  out  3  APB protection
psel_o  out  1  APB select
penable_o  out  1  APB enable
pwrite_o  out  1  APB direction
pwdata_o  out  DATA_WIDTH  APB write data
pstrb_o  out  DATA_WIDTH/8  APB strobes
pready_i  in  1  slave ready
prdata_i  in  DATA_WIDTH  slave read data
pslverr_i  in  1  slave error

Behaviour:

Reset (preset high, asynchronous):
- state=IDLE; all APB outputs 0.
- rsp_valid_o, rsp_rdata_o, rsp_slverr_o, rsp_timeout_o = 0; wait counter = 0.
- req_ready_o = (state==IDLE), so it is 1 during and after reset.
- Reset asserted mid-transfer aborts immediately: psel_o/penable_o drop asynchronously and any pending response is discarded.

FSM states: IDLE, SETUP, ACCESS, RESP.

IDLE:
- req_ready_o=1; psel_o=0, penable_o=0.
- On req_valid_i && req_ready_o: register addr, write, wdata, prot and strb into the APB output regs, then go to SETUP.
- pstrb_o is forced to 0 when req_write_i=0 (APB4 read rule).

SETUP (exactly 1 cycle):
- psel_o=1, penable_o=0; then go to ACCESS.

ACCESS:
- psel_o=1, penable_o=1.
- If pready_i=1:
  - capture rsp_slverr_o=pslverr_i, rsp_timeout_o=0.
  - capture rsp_rdata_o = prdata_i for reads, 0 for writes.
  - go to RESP.
- Else wait counter +1.
- If TIMEOUT_CYCLES>0 and the counter reaches TIMEOUT_CYCLES with pready_i still 0: go to RESP with rsp_slverr_o=1, rsp_timeout_o=1, rsp_rdata_o=0.
- pready_i sampled high in the same cycle the counter hits the limit counts as completion, not timeout.
- Counter width is $clog2(TIMEOUT_CYCLES+1). It clears on entry to SETUP and never wraps.

RESP:
- psel_o=0, penable_o=0; rsp_valid_o=1.
- Response fields are held stable until rsp_ready_i=1, then go to IDLE and clear rsp_valid_o.
- No new request is accepted while in RESP (single outstanding).

Stability and timing:
- paddr_o, pwrite_o, pwdata_o, pstrb_o and pprot_o hold the captured values from SETUP through the end of ACCESS, and keep them until the next acceptance.
- Minimum latency: request accepted at edge k; SETUP in cycle k; ACCESS in cycle k+1; rsp_valid_o=1 in cycle k+2 (zero wait states).
- Peak throughput is one transfer per 4 cycles when rsp_ready_i is tied high.

Test Plan:
- Write, zero wait: req addr=0x08, wdata=0xA5A5_0001, strb=0xF, pready tied 1 -> psel 2 cycles, penable 1 cycle, pwrite=1, pstrb=0xF; rsp_valid 2 cycles after accept; slverr=0, rdata=0.
- Read, 3 wait states: req addr=0x04 read, strb=0xF; pready low 3 ACCESS cycles, then high with prdata=0x1234_5678 -> pstrb=0, penable high 4 cycles, rsp_rdata=0x1234_5678, slverr=0, timeout=0.
- Slave error plus backpressure: pslverr=1 with pready; rsp_ready held low 5 cycles -> rsp_valid/rsp_slverr=1 stable 6 cycles, req_ready=0 throughout, then IDLE.
- Timeout: TIMEOUT_CYCLES=4, pready never asserted -> penable drops after exactly 4 wait cycles; rsp_slverr=1, rsp_timeout=1, rdata=0. Repeat with pready asserted on the limit cycle -> normal completion.
- Reset mid-ACCESS: assert preset during wait state -> psel/penable/rsp_valid 0 immediately, req_ready=1. After release, a new read completes normally.
